// File: rtl/adi2axis_capture_ctrl.sv
// adi2axis_capture_ctrl
// Capture sequencer between the ADI sample FIFO interface and the DMA-facing
// AXI-Stream master. A software start arms the block, which optionally waits
// for dsync and then gates exactly num_bytes of samples into one AXIS packet.
// The final beat carries TLAST and a partial TSTRB. The ADI side has no
// backpressure, so beats that cannot be loaded are dropped and flagged.
//
// Ports
//   AXIS_ACLK, AXIS_ARESET          clock, synchronous active-high reset
//   ctrl_start / ctrl_abort         one-cycle control pulses
//   ctrl_sync_en                    first beat must coincide with dsync
//   num_bytes                       capture length, sampled on accepted start
//   ddata / dvalid / dsync          ADI sample stream
//   ovf                             one-cycle pulse per dropped beat
//   M_AXIS_*                        AXI-Stream master (single output register)
//   stat_busy/done/ovf/err/beats    status towards the register file
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no capture; output register may still hold an aborted beat
// ARMED  | capture started, waiting for dvalid&dsync to take the first beat
// RUN    | every dvalid is a beat until beats_total beats are loaded
// FLUSH  | last beat loaded, waiting for its handshake

module adi2axis_capture_ctrl #(
    parameter int C_M_AXIS_TDATA_NUM_BYTES = 8
) (
    input  logic                                  AXIS_ACLK,
    input  logic                                  AXIS_ARESET,
    input  logic                                  ctrl_start,
    input  logic                                  ctrl_abort,
    input  logic                                  ctrl_sync_en,
    input  logic [31:0]                           num_bytes,
    input  logic [C_M_AXIS_TDATA_NUM_BYTES*8-1:0] ddata,
    input  logic                                  dvalid,
    input  logic                                  dsync,
    output logic                                  ovf,
    output logic                                  M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_NUM_BYTES*8-1:0] M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_NUM_BYTES-1:0]   M_AXIS_TSTRB,
    output logic                                  M_AXIS_TLAST,
    input  logic                                  M_AXIS_TREADY,
    output logic                                  stat_busy,
    output logic                                  stat_done,
    output logic                                  stat_ovf,
    output logic                                  stat_err,
    output logic [31:0]                           stat_beats
);

    localparam int N = C_M_AXIS_TDATA_NUM_BYTES;
    localparam int L = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_FLUSH = 2'd3
    } state_t;

    state_t state_q, state_d;

    // beats still to be loaded; the load that sees 1 is the packet end
    logic [32:0]    beats_left_q;
    logic [N-1:0]   last_strb_q;

    logic           tvalid_q;
    logic [N*8-1:0] tdata_q;
    logic [N-1:0]   tstrb_q;
    logic           tlast_q;

    logic           ovf_q;
    logic           done_q;
    logic           ovf_sticky_q;
    logic           err_q;
    logic [31:0]    beats_q;

    logic           hs;
    logic           loadable;
    logic           busy;
    logic           abort_act;
    logic           start_acc;
    logic           start_zero;
    logic           start_go;
    logic           eligible;
    logic           load;
    logic           drop;
    logic           last_beat;
    logic [32:0]    bytes_round;
    logic [32:0]    beats_total;

    // partial strobe for the final beat: low (num_bytes mod N) lanes, or all
    function automatic logic [N-1:0] strb_for(input logic [31:0] nbytes);
        logic [N-1:0] s;
        logic [31:0]  rem;
        rem = nbytes & 32'(N - 1);
        s   = '0;
        for (int i = 0; i < N; i++) begin
            if (32'(i) < rem) begin
                s[i] = 1'b1;
            end
        end
        if (rem == 32'd0) begin
            s = '1;
        end
        return s;
    endfunction

    // 33-bit round-up so a length of 0xFFFFFFFF does not wrap to zero beats
    assign bytes_round = {1'b0, num_bytes} + 33'(N - 1);
    assign beats_total = bytes_round >> L;

    always_comb begin
        hs         = tvalid_q & M_AXIS_TREADY;
        loadable   = ~tvalid_q | hs;
        busy       = (state_q != ST_IDLE) | tvalid_q;
        abort_act  = ctrl_abort & (state_q != ST_IDLE);
        // abort in the same cycle always wins over start
        start_acc  = ctrl_start & ~ctrl_abort & ~busy;
        start_zero = start_acc & (num_bytes == 32'd0);
        start_go   = start_acc & (num_bytes != 32'd0);
        eligible   = dvalid & ~abort_act &
                     ((state_q == ST_RUN) | ((state_q == ST_ARMED) & dsync));
        load       = eligible & loadable;
        drop       = eligible & ~loadable;
        last_beat  = (beats_left_q == 33'd1);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_go) begin
                    state_d = ctrl_sync_en ? ST_ARMED : ST_RUN;
                end
            end
            ST_ARMED: begin
                if (abort_act) begin
                    state_d = ST_IDLE;
                end else if (load) begin
                    state_d = last_beat ? ST_FLUSH : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort_act) begin
                    state_d = ST_IDLE;
                end else if (load && last_beat) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (abort_act || hs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge AXIS_ACLK) begin
        if (AXIS_ARESET) begin
            state_q      <= ST_IDLE;
            beats_left_q <= '0;
            last_strb_q  <= '0;
            tvalid_q     <= 1'b0;
            tdata_q      <= '0;
            tstrb_q      <= '0;
            tlast_q      <= 1'b0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
            ovf_sticky_q <= 1'b0;
            err_q        <= 1'b0;
            beats_q      <= '0;
        end else begin
            state_q <= state_d;
            ovf_q   <= drop;

            if (start_zero) begin
                err_q <= 1'b1;
            end

            if (start_go) begin
                done_q       <= 1'b0;
                ovf_sticky_q <= 1'b0;
                err_q        <= 1'b0;
                beats_q      <= '0;
                beats_left_q <= beats_total;
                last_strb_q  <= strb_for(num_bytes);
            end

            if (abort_act) begin
                err_q <= 1'b1;
            end

            if (drop) begin
                ovf_sticky_q <= 1'b1;
            end

            if ((state_q == ST_FLUSH) && hs && !abort_act) begin
                done_q <= 1'b1;
            end

            if (load) begin
                tvalid_q     <= 1'b1;
                tdata_q      <= ddata;
                tstrb_q      <= last_beat ? last_strb_q : '1;
                tlast_q      <= last_beat;
                beats_left_q <= beats_left_q - 33'd1;
                if (beats_q != 32'hFFFF_FFFF) begin
                    beats_q <= beats_q + 32'd1;
                end
            end else if (hs) begin
                tvalid_q <= 1'b0;
            end else if (abort_act && tvalid_q) begin
                // a stranded beat closes the packet so the DMA sees an end
                tlast_q <= 1'b1;
            end
        end
    end

    assign ovf           = ovf_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TSTRB  = tstrb_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign stat_busy     = busy;
    assign stat_done     = done_q;
    assign stat_ovf      = ovf_sticky_q;
    assign stat_err      = err_q;
    assign stat_beats    = beats_q;

endmodule
